// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared types for the instruction-fetch sequencer:
//   fetch_state_t : FSM states of ifetch_ctrl (FETCH, DRAIN, HALTED)
//   fetch_entry_t : one prefetch FIFO entry, {pc, inst}
//   NOP_INST      : instruction presented on inst while the FIFO is empty
//   align_pc()    : clears the byte-offset bits of a PC
// ---------------------------------------------------------------------------
package ifetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// ---------------------------------------------------------------------------
// ifetch_if
// Bundles the imem port, the decode handshake, redirect/halt control and the
// performance counters of ifetch_ctrl.
//   imem_addr / imem_dout          : imem byte address and same-cycle data
//   inst_valid / inst / inst_pc    : FIFO head towards decode
//   inst_ready                     : decode accepts the head
//   redirect_valid / redirect_pc   : taken branch, flush and refetch
//   halt_req / halted              : stop fetching, drain, report halted
//   perf_fetch_cnt / perf_stall_cnt: performance counters (0 when not built)
// Modports: master = ifetch_ctrl side, slave = imem/decode/environment side.
// ---------------------------------------------------------------------------
interface ifetch_if #(
    parameter int IMEM_ADDR_WIDTH = 10
);
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]                imem_dout;
    logic                       inst_valid;
    logic [31:0]                inst;
    logic [31:0]                inst_pc;
    logic                       inst_ready;
    logic                       redirect_valid;
    logic [31:0]                redirect_pc;
    logic                       halt_req;
    logic                       halted;
    logic [31:0]                perf_fetch_cnt;
    logic [31:0]                perf_stall_cnt;

    modport master (
        output imem_addr, inst_valid, inst, inst_pc, halted,
               perf_fetch_cnt, perf_stall_cnt,
        input  imem_dout, inst_ready, redirect_valid, redirect_pc, halt_req
    );

    modport slave (
        input  imem_addr, inst_valid, inst, inst_pc, halted,
               perf_fetch_cnt, perf_stall_cnt,
        output imem_dout, inst_ready, redirect_valid, redirect_pc, halt_req
    );
endinterface

// File: rtl/ifetch_fifo.sv
// ---------------------------------------------------------------------------
// ifetch_fifo
// Synchronous prefetch FIFO of fetch_entry_t. Pointers carry one extra wrap
// bit so full and empty are distinguished without a counter.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (pointers only)
//   push_i / wdata_i  : write an entry at the tail
//   pop_i             : drop the head entry
//   flush_i           : empty the FIFO; wins over push and pop
//   rdata_o           : head entry (meaningless while empty_o)
//   full_o / empty_o  : occupancy flags
// ---------------------------------------------------------------------------
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

    fetch_entry_t mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifetch_ctrl
// Fetch sequencer in front of a combinational imem. Owns the fetch PC, reads
// imem every fetching cycle, stores {pc, inst} into ifetch_fifo and presents
// the head to decode over valid/ready. Supports branch redirect (flush and
// refetch) and halt with drain.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : ifetch_if.master (imem port, decode handshake, redirect, halt,
//            perf counters)
// Configuration macro:
//   IFETCH_PERF_EN : when defined, builds 32-bit wrapping fetch and stall
//                    counters; otherwise both perf outputs are tied to 0.
// ---------------------------------------------------------------------------
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int          IMEM_ADDR_WIDTH = 10,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     reset,
    ifetch_if.master bus
);
    fetch_state_t state_q;
    logic         halted_q;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         full, empty, push, pop;
    fetch_entry_t head, wentry;

    // A redirect kills the head shown this cycle and suppresses the push, so
    // neither pop nor push may take effect alongside it.
    assign pop  = !empty && bus.inst_ready && !bus.redirect_valid;
    assign push = (state_q == FETCH) && !bus.halt_req && !bus.redirect_valid &&
                  (!full || pop);

    assign wentry.pc   = fetch_pc_q;
    assign wentry.inst = bus.imem_dout;

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid),
        .wdata_i (wentry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = align_pc(bus.redirect_pc);
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Redirect in FETCH keeps fetching (halt is looked at again next cycle);
    // in DRAIN/HALTED it only flushes, the state follows halt_req as usual.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (bus.halt_req && !bus.redirect_valid) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.halt_req) begin
                        state_q <= FETCH;
                    end else if (empty) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!bus.halt_req) begin
                        state_q  <= FETCH;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= FETCH;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_addr  = fetch_pc_q[IMEM_ADDR_WIDTH-1:0];
    assign bus.inst_valid = !empty;
    assign bus.inst       = empty ? NOP_INST : head.inst;
    assign bus.inst_pc    = head.pc;
    assign bus.halted     = halted_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (push) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if ((state_q == FETCH) && full && !pop) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign bus.perf_fetch_cnt = perf_fetch_q;
    assign bus.perf_stall_cnt = perf_stall_q;
`else
    assign bus.perf_fetch_cnt = 32'h0;
    assign bus.perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifetch_ctrl
// Directed bench for ifetch_ctrl. Inputs change on the falling edge, outputs
// are sampled on the falling edge after each rising edge. imem holds
// 32'h100 + word_index. A second instance with RESET_PC = 32'hFFFF_FFFC
// covers the PC wrap. Perf expectations follow IFETCH_PERF_EN.
// ---------------------------------------------------------------------------
module tb_ifetch_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifetch_if #(.IMEM_ADDR_WIDTH(10)) bus   ();
    ifetch_if #(.IMEM_ADDR_WIDTH(10)) bus_w ();

    logic [31:0] imem [256];
    assign bus.imem_dout   = imem[bus.imem_addr[9:2]];
    assign bus_w.imem_dout = imem[bus_w.imem_addr[9:2]];

    ifetch_ctrl #(
        .IMEM_ADDR_WIDTH (10),
        .FIFO_DEPTH      (4),
        .RESET_PC        (32'h0000_0000)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ifetch_ctrl #(
        .IMEM_ADDR_WIDTH (10),
        .FIFO_DEPTH      (4),
        .RESET_PC        (32'hFFFF_FFFC)
    ) u_dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef IFETCH_PERF_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h100 + i;
        reset                = 1'b1;
        bus.inst_ready       = 1'b1;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = 32'h0;
        bus.halt_req         = 1'b0;
        bus_w.inst_ready     = 1'b1;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc    = 32'h0;
        bus_w.halt_req       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid",   {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_halted",  {31'd0, bus.halted},     32'd0);
        chk("rst_addr",    {22'd0, bus.imem_addr},  32'd0);
        chk("rst_pfetch",  bus.perf_fetch_cnt,      32'd0);
        chk("rst_pstall",  bus.perf_stall_cnt,      32'd0);
        chk("rst_w_addr",  {22'd0, bus_w.imem_addr}, 32'h3FC);
        chk("rst_w_valid", {31'd0, bus_w.inst_valid}, 32'd0);
        reset = 1'b0;

        // 1: streaming with ready held high, plus wrap on the second instance
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("s1_valid", {31'd0, bus.inst_valid}, 32'd1);
            chk("s1_pc",    bus.inst_pc, 32'(4 * k));
            chk("s1_inst",  bus.inst,    32'h100 + 32'(k));
            if (k == 0) begin
                chk("wrap_pc0",   bus_w.inst_pc, 32'hFFFF_FFFC);
                chk("wrap_inst0", bus_w.inst,    32'h1FF);
            end
            if (k == 1) begin
                chk("wrap_pc1",   bus_w.inst_pc, 32'h0);
                chk("wrap_inst1", bus_w.inst,    32'h100);
            end
        end
        chk("s1_pfetch", bus.perf_fetch_cnt, perf_exp(32'd8));
        chk("s1_pstall", bus.perf_stall_cnt, 32'd0);

        // Reset mid-stream discards the FIFO
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_valid",  {31'd0, bus.inst_valid}, 32'd0);
        chk("mrst_addr",   {22'd0, bus.imem_addr},  32'd0);
        chk("mrst_pfetch", bus.perf_fetch_cnt,      32'd0);

        // 2: backpressure fills the FIFO, then 10 stalled cycles
        bus.inst_ready = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("s2_full_valid", {31'd0, bus.inst_valid}, 32'd1);
        chk("s2_full_pc",    bus.inst_pc,             32'd0);
        chk("s2_full_addr",  {22'd0, bus.imem_addr},  32'd16);
        repeat (10) @(negedge clk);
        chk("s2_hold_addr", {22'd0, bus.imem_addr}, 32'd16);
        chk("s2_hold_pc",   bus.inst_pc,            32'd0);
        chk("s2_pstall",    bus.perf_stall_cnt,     perf_exp(32'd10));
        chk("s2_pfetch",    bus.perf_fetch_cnt,     perf_exp(32'd4));
        bus.inst_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("s2_drain_pc",   bus.inst_pc, 32'(4 * k));
            chk("s2_drain_inst", bus.inst,    32'h100 + 32'(k));
        end
        chk("s2_end_addr", {22'd0, bus.imem_addr}, 32'd32);

        // 3: redirect while full
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h43;
        @(negedge clk);
        chk("s3_valid0", {31'd0, bus.inst_valid}, 32'd0);
        chk("s3_addr",   {22'd0, bus.imem_addr},  32'h40);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("s3_valid1", {31'd0, bus.inst_valid}, 32'd1);
        chk("s3_pc1",    bus.inst_pc,             32'h40);
        chk("s3_inst1",  bus.inst,                32'h110);
        @(negedge clk);
        chk("s3_pc2",    bus.inst_pc,             32'h44);
        chk("s3_inst2",  bus.inst,                32'h111);

        // 4: buffer 3 entries, then halt and drain
        bus.inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("s4_head", bus.inst_pc,            32'h44);
        chk("s4_addr", {22'd0, bus.imem_addr}, 32'h50);
        bus.halt_req   = 1'b1;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        chk("s4_pop1_pc", bus.inst_pc,            32'h48);
        chk("s4_pop1_h",  {31'd0, bus.halted},    32'd0);
        chk("s4_pop1_a",  {22'd0, bus.imem_addr}, 32'h50);
        @(negedge clk);
        chk("s4_pop2_pc", bus.inst_pc,            32'h4C);
        @(negedge clk);
        chk("s4_empty_v", {31'd0, bus.inst_valid}, 32'd0);
        chk("s4_empty_h", {31'd0, bus.halted},     32'd0);
        @(negedge clk);
        chk("s4_halted",  {31'd0, bus.halted},    32'd1);
        chk("s4_h_addr",  {22'd0, bus.imem_addr}, 32'h50);
        @(negedge clk);
        chk("s4_halted2", {31'd0, bus.halted},     32'd1);
        chk("s4_h_valid", {31'd0, bus.inst_valid}, 32'd0);
        bus.halt_req = 1'b0;
        @(negedge clk);
        chk("s4_unhalt",   {31'd0, bus.halted},     32'd0);
        chk("s4_unhalt_v", {31'd0, bus.inst_valid}, 32'd0);
        @(negedge clk);
        chk("s4_resume_v",  {31'd0, bus.inst_valid}, 32'd1);
        chk("s4_resume_pc", bus.inst_pc,             32'h50);
        chk("s4_resume_in", bus.inst,                32'h114);
        chk("s4_pfetch",    bus.perf_fetch_cnt,      perf_exp(32'd13));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
